// File: rtl/if_stage_pipe.sv
// if_stage_pipe: instruction-fetch stage with PC, IF/ID register, stall/flush control and saturating debug counters
// Ports:
//   CLK, RST_N                  rising-edge clock, asynchronous active-low reset
//   HZld, IF_ID_ld              hazard-unit load enables for PC and IF/ID
//   branch_taken, branch_target ID-stage taken-branch redirect
//   imem_data / imem_addr       combinational instruction memory read port (addr = PC)
//   IF_ID_instr/pc4/valid       IF/ID pipeline register outputs
//   fetch_state                 00 RUN, 01 STALL, 10 FLUSH
//   stall_cnt, flush_cnt        saturating stall-cycle and flush counters
module if_stage_pipe #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             HZld,
    input  logic             IF_ID_ld,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic [31:0]      imem_data,
    output logic [31:0]      imem_addr,
    output logic [31:0]      IF_ID_instr,
    output logic [31:0]      IF_ID_pc4,
    output logic             IF_ID_valid,
    output logic [1:0]       fetch_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef enum logic [1:0] {RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10} state_t;
    state_t      state, state_next;
    logic [31:0] pc, pc_next, instr_next, pc4_next;
    logic        valid_next;
    logic [31:0] pc_plus4;
    assign pc_plus4    = pc + 32'd4;
    assign imem_addr   = pc;
    assign fetch_state = state;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc          <= RESET_VEC;
            IF_ID_instr <= NOP_INSTR;
            IF_ID_pc4   <= '0;
            IF_ID_valid <= 1'b0;
            state       <= RUN;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            pc          <= pc_next;
            IF_ID_instr <= instr_next;
            IF_ID_pc4   <= pc4_next;
            IF_ID_valid <= valid_next;
            state       <= state_next;
            if (state_next == STALL && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
            if (state_next == FLUSH && !(&flush_cnt))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
    // A branch sitting in a stalled ID stage is ignored; it is re-presented once HZld returns.
    always_comb begin
        pc_next    = pc;
        instr_next = IF_ID_instr;
        pc4_next   = IF_ID_pc4;
        valid_next = IF_ID_valid;
        state_next = RUN;
        if (!HZld) begin
            state_next = STALL;
            if (IF_ID_ld) begin
                instr_next = NOP_INSTR;
                pc4_next   = '0;
                valid_next = 1'b0;
            end
        end else if (branch_taken) begin
            state_next = FLUSH;
            pc_next    = {branch_target[31:2], 2'b00};
            instr_next = NOP_INSTR;
            pc4_next   = '0;
            valid_next = 1'b0;
        end else begin
            pc_next = pc_plus4;
            if (IF_ID_ld) begin
                instr_next = imem_data;
                pc4_next   = pc_plus4;
                valid_next = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_if_stage_pipe.sv
// tb_if_stage_pipe: directed scoreboard bench for if_stage_pipe (counters narrowed to 2 bits to reach saturation)
module tb_if_stage_pipe;
    localparam int CW = 2;
    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          HZld = 1'b1, IF_ID_ld = 1'b1, branch_taken = 1'b0;
    logic [31:0]   branch_target = '0;
    logic [31:0]   imem_data, imem_addr, IF_ID_instr, IF_ID_pc4;
    logic          IF_ID_valid;
    logic [1:0]    fetch_state;
    logic [CW-1:0] stall_cnt, flush_cnt;
    int            checks = 0, errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] addr, pc4, instr;
        logic        chk_pc4, valid;
        logic [1:0]  st;
        logic [CW-1:0] sc, fc;
    } exp_t;
    exp_t sb[$];

    if_stage_pipe #(.CNT_W(CW)) dut (
        .CLK(CLK), .RST_N(RST_N), .HZld(HZld), .IF_ID_ld(IF_ID_ld),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_data(imem_data), .imem_addr(imem_addr), .IF_ID_instr(IF_ID_instr),
        .IF_ID_pc4(IF_ID_pc4), .IF_ID_valid(IF_ID_valid), .fetch_state(fetch_state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 CLK = ~CLK;
    assign imem_data = imem_addr + 32'hA0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic hz, input logic ld, input logic bt,
                        input logic [31:0] tgt, input logic [31:0] addr, input logic [31:0] pc4,
                        input logic chk_pc4, input logic [31:0] instr, input logic valid,
                        input logic [1:0] st, input int sc, input int fc);
        exp_t e;
        HZld = hz; IF_ID_ld = ld; branch_taken = bt; branch_target = tgt;
        e.tag = tag; e.addr = addr; e.pc4 = pc4; e.chk_pc4 = chk_pc4; e.instr = instr;
        e.valid = valid; e.st = st; e.sc = CW'(sc); e.fc = CW'(fc);
        sb.push_back(e);
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".addr"}, imem_addr, e.addr);
        chk({e.tag, ".instr"}, IF_ID_instr, e.instr);
        if (e.chk_pc4) chk({e.tag, ".pc4"}, IF_ID_pc4, e.pc4);
        chk({e.tag, ".valid"}, 32'(IF_ID_valid), 32'(e.valid));
        chk({e.tag, ".state"}, 32'(fetch_state), 32'(e.st));
        chk({e.tag, ".stall_cnt"}, 32'(stall_cnt), 32'(e.sc));
        chk({e.tag, ".flush_cnt"}, 32'(flush_cnt), 32'(e.fc));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".addr"}, imem_addr, 32'h0);
        chk({tag, ".instr"}, IF_ID_instr, 32'h0);
        chk({tag, ".pc4"}, IF_ID_pc4, 32'h0);
        chk({tag, ".valid"}, 32'(IF_ID_valid), 32'h0);
        chk({tag, ".state"}, 32'(fetch_state), 32'h0);
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'h0);
        chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'h0);
    endtask

    initial begin
        #3;
        chk_reset("t1_reset");
        RST_N = 1'b1;
        //    tag        hz ld bt target        addr          pc4          cp instr        v  st sc fc
        step("t1_run0", 1, 1, 0, 32'h0,        32'h4,        32'h4,        1, 32'hA0,        1, 0, 0, 0);
        step("t1_run1", 1, 1, 0, 32'h0,        32'h8,        32'h8,        1, 32'hA4,        1, 0, 0, 0);
        step("t1_run2", 1, 1, 0, 32'h0,        32'hC,        32'hC,        1, 32'hA8,        1, 0, 0, 0);
        step("t1_run3", 1, 1, 0, 32'h0,        32'h10,       32'h10,       1, 32'hAC,        1, 0, 0, 0);
        step("t2_stl0", 0, 0, 0, 32'h0,        32'h10,       32'h10,       1, 32'hAC,        1, 1, 1, 0);
        step("t2_stl1", 0, 0, 0, 32'h0,        32'h10,       32'h10,       1, 32'hAC,        1, 1, 2, 0);
        step("t2_res0", 1, 1, 0, 32'h0,        32'h14,       32'h14,       1, 32'hB0,        1, 0, 2, 0);
        step("t2_res1", 1, 1, 0, 32'h0,        32'h18,       32'h18,       1, 32'hB4,        1, 0, 2, 0);
        step("t2_res2", 1, 1, 0, 32'h0,        32'h1C,       32'h1C,       1, 32'hB8,        1, 0, 2, 0);
        step("t2_res3", 1, 1, 0, 32'h0,        32'h20,       32'h20,       1, 32'hBC,        1, 0, 2, 0);
        step("t3_br",   1, 1, 1, 32'h103,      32'h100,      32'h0,        1, 32'h0,         0, 2, 2, 1);
        step("t3_aft",  1, 1, 0, 32'h0,        32'h104,      32'h104,      1, 32'h1A0,       1, 0, 2, 1);
        step("t4_hold", 0, 0, 1, 32'h200,      32'h104,      32'h104,      1, 32'h1A0,       1, 1, 3, 1);
        step("t4_br",   1, 1, 1, 32'h200,      32'h200,      32'h0,        1, 32'h0,         0, 2, 3, 2);
        step("t4_aft",  1, 1, 0, 32'h0,        32'h204,      32'h204,      1, 32'h2A0,       1, 0, 3, 2);
        step("bubble",  0, 1, 0, 32'h0,        32'h204,      32'h0,        0, 32'h0,         0, 1, 3, 2);
        step("ld_hold", 1, 0, 0, 32'h0,        32'h208,      32'h0,        0, 32'h0,         0, 0, 3, 2);
        step("t5_br",   1, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'h0,        1, 32'h0,         0, 2, 3, 3);
        step("t5_wrap", 1, 1, 0, 32'h0,        32'h0,        32'h0,        1, 32'h9C,        1, 0, 3, 3);
        step("t5_next", 1, 1, 0, 32'h0,        32'h4,        32'h4,        1, 32'hA0,        1, 0, 3, 3);
        step("t6_br",   1, 1, 1, 32'h40,       32'h40,       32'h0,        1, 32'h0,         0, 2, 3, 3);
        #3;
        RST_N = 1'b0;
        #1;
        chk_reset("t6_async");
        @(negedge CLK);
        RST_N = 1'b1;
        step("t6_run",  1, 1, 0, 32'h0,        32'h4,        32'h4,        1, 32'hA0,        1, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
